// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer geometry and colour constants
// for the framebuffer scanner.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_CELL_SHIFT = 4;

  localparam int FB_COLS = 40;
  localparam int FB_ROWS = 30;
  localparam int FB_BITS = 1200;

  typedef logic [11:0] rgb444_t;
  typedef logic [9:0]  cnt_t;

  localparam rgb444_t ON_COLOR   = 12'hFFF;
  localparam rgb444_t OFF_COLOR  = 12'h000;
  localparam rgb444_t GRID_COLOR = 12'h333;

endpackage

// File: rtl/vga_timing.sv
// Pixel enable, raster counters, sync decode and frame strobes
// for the framebuffer scanner.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic clock,
  input  logic reset,
  output logic pix_en,
  output cnt_t h_count,
  output cnt_t v_count,
  output logic hs_n,
  output logic vs_n,
  output logic frame_end,
  output logic frame_start
);

  localparam cnt_t H_LAST =
    cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST =
    cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t HS_LO = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_HI = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_LO = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_HI = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic pix_en_q, pix_en_d;
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  assign pix_en  = pix_en_q;
  assign h_count = h_q;
  assign v_count = v_q;

  assign hs_n = !((h_q >= HS_LO) && (h_q <= HS_HI));
  assign vs_n = !((v_q >= VS_LO) && (v_q <= VS_HI));

  assign frame_end =
    pix_en_q && (h_q == H_LAST) && (v_q == V_LAST);
  assign frame_start =
    pix_en_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/framebuffer_scanner.sv
// Snapshots the cell framebuffer per frame and scans it to VGA.
// FRAMEBUFFER_SCANNER_GRID_EN draws a grid over clear cells.
module framebuffer_scanner
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int CELL_SHIFT = VGA_CELL_SHIFT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FB_BITS-1:0] framebuffer,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_start
);

  localparam cnt_t H_VIS = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS = cnt_t'(V_VISIBLE);
`ifdef FRAMEBUFFER_SCANNER_GRID_EN
  localparam cnt_t CELL_MASK = cnt_t'((1 << CELL_SHIFT) - 1);
`endif

  logic pix_en;
  logic hs_n;
  logic vs_n;
  logic frame_end;
  cnt_t h_count;
  cnt_t v_count;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .pix_en      (pix_en),
    .h_count     (h_count),
    .v_count     (v_count),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

  logic [FB_BITS-1:0] snapshot_q, snapshot_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  rgb444_t            rgb_q, rgb_d;

  logic       visible;
  logic [10:0] row;
  logic [10:0] col;
  logic [10:0] idx;
  rgb444_t    cell_rgb;

  always_comb begin
    visible  = (h_count < H_VIS) && (v_count < V_VIS);
    row      = 11'(v_count >> CELL_SHIFT);
    col      = 11'(h_count >> CELL_SHIFT);
    idx      = row * 11'(FB_COLS) + col;
    cell_rgb = snapshot_q[idx] ? ON_COLOR : OFF_COLOR;
`ifdef FRAMEBUFFER_SCANNER_GRID_EN
    if (!snapshot_q[idx] &&
        (((h_count & CELL_MASK) == '0) ||
         ((v_count & CELL_MASK) == '0)))
      cell_rgb = GRID_COLOR;
`endif
  end

  // Sync and colour share one register stage so they stay aligned.
  always_comb begin
    snapshot_d = frame_end ? framebuffer : snapshot_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    rgb_d      = rgb_q;
    if (pix_en) begin
      hs_d  = hs_n;
      vs_d  = vs_n;
      rgb_d = visible ? cell_rgb : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snapshot_q <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      rgb_q      <= '0;
    end else begin
      snapshot_q <= snapshot_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
    end
  end

  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_r  = rgb_q[11:8];
  assign vga_g  = rgb_q[7:4];
  assign vga_b  = rgb_q[3:0];

endmodule

// File: tb/tb_framebuffer_scanner.sv
// Bench for framebuffer_scanner on a shrunken raster: a time-based
// reference model checks every clock, plus table-driven pixel probes.
module tb_framebuffer_scanner;

  localparam int HV = 80;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VV = 60;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int CS = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1199:0] framebuffer = '0;
  logic          vga_hs;
  logic          vga_vs;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;
  logic          frame_start;

  framebuffer_scanner #(
    .H_VISIBLE  (HV),
    .H_FRONT    (HF),
    .H_SYNC     (HS),
    .H_BACK     (HB),
    .V_VISIBLE  (VV),
    .V_FRONT    (VF),
    .V_SYNC     (VS),
    .V_BACK     (VB),
    .CELL_SHIFT (CS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .framebuffer (framebuffer),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  // Model: k counts clock edges since reset release; frame f shows
  // whatever the framebuffer held at edge 2*FRAME*f.
  int            k = 0;
  int            cyc = 0;
  logic [1199:0] snap [0:15];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      k <= 0;
      for (int i = 0; i < 16; i++) snap[i] <= '0;
    end else begin
      k <= k + 1;
      if ((k + 1) % (2 * FRAME) == 0 && (k + 1) / (2 * FRAME) < 16)
        snap[(k + 1) / (2 * FRAME)] <= framebuffer;
    end
  end

  function automatic void pin_pos(input int kk, output bit valid,
                                  output int f, output int x,
                                  output int y);
    int q;
    valid = (kk >= 2);
    q = valid ? kk / 2 - 1 : 0;
    f = q / FRAME;
    x = (q % FRAME) % HT;
    y = (q % FRAME) / HT;
  endfunction

  always @(negedge clock) begin
    bit v;
    int f, x, y;
    logic e_hs, e_vs, e_fs;
    logic [11:0] e_rgb;
    if (run) begin
      pin_pos(k, v, f, x, y);
      e_fs = (k % 2 == 1) && ((k / 2) % FRAME == 0);
      e_hs = 1'b1;
      e_vs = 1'b1;
      e_rgb = 12'h000;
      if (v) begin
        e_hs = !(x >= HV + HF && x < HV + HF + HS);
        e_vs = !(y >= VV + VF && y < VV + VF + VS);
        if (x < HV && y < VV && f < 16)
          e_rgb = snap[f][(y >> CS) * 40 + (x >> CS)] ?
                  12'hFFF : 12'h000;
      end
      vectors++;
      if ({vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start} !==
          {e_hs, e_vs, e_rgb, e_fs}) begin
        miscompares++;
        $display("FAIL scan k=%0d f=%0d x=%0d y=%0d: got hs=%b vs=%b rgb=%h fs=%b, want hs=%b vs=%b rgb=%h fs=%b",
                 k, f, x, y, vga_hs, vga_vs, {vga_r, vga_g, vga_b},
                 frame_start, e_hs, e_vs, e_rgb, e_fs);
      end
    end
  end

  int fs_q[$];
  int vsl_q[$];
  int vs_low = 0;

  always @(negedge clock) begin
    if (run && !reset) begin
      if (!vga_vs) vs_low++;
      if (frame_start) begin
        fs_q.push_back(cyc);
        vsl_q.push_back(vs_low);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [1199:0] rand_fb();
    logic [1215:0] t;
    for (int i = 0; i < 38; i++) t[i*32 +: 32] = $urandom();
    return t[1199:0];
  endfunction

  task automatic wait_pin(input int tf, input int tx, input int ty,
                          output bit ok);
    bit v;
    int f, x, y;
    ok = 1'b0;
    for (int n = 0; n < 3 * FRAME && !ok; n++) begin
      @(negedge clock);
      pin_pos(k, v, f, x, y);
      if (v && f == tf && x == tx && y == ty) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_pin f=%0d x=%0d y=%0d: timed out", tf, tx, ty);
    end
  endtask

  task automatic set_at_boundary(input int f, input logic [1199:0] val,
                                 input bit noise);
    bit done = 1'b0;
    for (int n = 0; n < 3 * FRAME && !done; n++) begin
      @(negedge clock);
      if (k == 2 * FRAME * f - 1) begin
        framebuffer = val;
        done = 1'b1;
      end else if (noise && $urandom_range(31) == 0) begin
        framebuffer = rand_fb();
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL boundary f=%0d: timed out", f);
    end
  endtask

  typedef struct {
    int          frame;
    int          x;
    int          y;
    logic [11:0] rgb;
    string       name;
  } probe_t;

  localparam int NP = 21;
  probe_t        tab [NP];
  logic [1199:0] pat [0:5];

  task automatic probe(input int i);
    bit ok;
    wait_pin(tab[i].frame, tab[i].x, tab[i].y, ok);
    if (ok) chk(tab[i].name, int'({vga_r, vga_g, vga_b}),
                int'(tab[i].rgb));
  endtask

  initial begin
    bit ok;
    int cnt;
    int rel;

    tab[0]  = '{0,  0,  0, 12'h000, "f0_origin_off"};
    tab[1]  = '{0, 10, 10, 12'h000, "f0_mid_off"};
    tab[2]  = '{1, 82,  5, 12'h000, "f1_hblank"};
    tab[3]  = '{1, 10, 10, 12'hFFF, "f1_mid_on"};
    tab[4]  = '{1, 79, 59, 12'hFFF, "f1_last_on"};
    tab[5]  = '{1,  5, 61, 12'h000, "f1_vblank"};
    tab[6]  = '{2,  0,  0, 12'hFFF, "b0_origin"};
    tab[7]  = '{2,  2,  0, 12'h000, "b0_right"};
    tab[8]  = '{2,  1,  1, 12'hFFF, "b0_corner"};
    tab[9]  = '{2,  0,  2, 12'h000, "b0_below"};
    tab[10] = '{2, 40, 30, 12'h000, "b0_mid"};
    tab[11] = '{3,  0,  0, 12'h000, "b1199_origin"};
    tab[12] = '{3, 79, 57, 12'h000, "b1199_above"};
    tab[13] = '{3, 78, 58, 12'hFFF, "b1199_corner"};
    tab[14] = '{3, 77, 59, 12'h000, "b1199_left"};
    tab[15] = '{3, 79, 59, 12'hFFF, "b1199_last"};
    tab[16] = '{4, 40, 10, 12'hFFF, "iso_before_clear"};
    tab[17] = '{4, 40, 40, 12'hFFF, "iso_after_clear"};
    tab[18] = '{4, 79, 59, 12'hFFF, "iso_frame_end"};
    tab[19] = '{5,  0,  0, 12'h000, "iso_next_origin"};
    tab[20] = '{5, 40,  5, 12'h000, "iso_next_mid"};

    pat[0] = '0;
    pat[1] = '1;
    pat[2] = '0;
    pat[2][0] = 1'b1;
    pat[3] = '0;
    pat[3][1199] = 1'b1;
    pat[4] = '1;
    pat[5] = '0;

    #1 reset = 1'b1;
    #1 run = 1'b1;
    repeat (5) @(negedge clock);
    chk("reset_hs", int'(vga_hs), 1);
    chk("reset_vs", int'(vga_vs), 1);
    chk("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("reset_fs", int'(frame_start), 0);
    framebuffer = '1;
    reset = 1'b0;

    for (int f = 0; f <= 5; f++) begin
      for (int i = 0; i < NP; i++)
        if (tab[i].frame == f && tab[i].y < 20) probe(i);
      if (f == 4) begin
        wait_pin(4, 0, 20, ok);
        framebuffer = '0;
      end
      for (int i = 0; i < NP; i++)
        if (tab[i].frame == f && tab[i].y >= 20) probe(i);
      if (f < 5) set_at_boundary(f + 1, pat[f + 1], f < 4);
    end

    wait_pin(5, 81, 5, ok);
    chk("pre_reset_hs_low", int'(vga_hs), 0);
    reset = 1'b1;
    #1;
    chk("midreset_hs", int'(vga_hs), 1);
    chk("midreset_vs", int'(vga_vs), 1);
    chk("midreset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("midreset_fs", int'(frame_start), 0);
    repeat (3) @(negedge clock);
    fs_q.delete();
    vsl_q.delete();
    rel = cyc;
    framebuffer = rand_fb();
    reset = 1'b0;

    cnt = 0;
    repeat (2 * HT) begin
      @(negedge clock);
      if (!vga_hs) cnt++;
    end
    chk("hs_low_per_line", cnt, 2 * HS);

    set_at_boundary(1, rand_fb(), 1'b1);
    wait_pin(1, 40, 5, ok);

    chk("fs_count", fs_q.size(), 2);
    if (fs_q.size() >= 2) begin
      chk("fs_after_release", fs_q[0] - rel, 1);
      chk("fs_period", fs_q[1] - fs_q[0], 2 * FRAME);
      chk("vs_low_per_frame", vsl_q[1] - vsl_q[0], 2 * VS * HT);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
